stepper_ramp_sequencer: RTL and testbench

Downstream motion stage for one PmodSTEP axis. It consumes the per-axis `en` / `dir` levels produced by the toggle and limit logic and drives the four coil lines directly. It replaces the fixed-rate divider plus driver pair with a trapezoidal accelerate/cruise/decelerate step-rate generator, a phase sequencer, and a signed position counter. One instance is used per motor.

---
 rtl/stepper_ramp_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_stepper_ramp_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// stepper_ramp_sequencer
//
// One-axis stepper motion stage. It turns a run request and a direction level
// into a trapezoidal step-rate profile and drives the coil lines directly.
// The profile accelerates from MAX_PERIOD down to MIN_PERIOD, cruises there,
// and decelerates back to MAX_PERIOD before stopping. A signed position
// counter tracks every step that is taken.
//
// Build option:
//   HALF_STEP_EN  defined   -> 8-entry half-step coil sequence, 3-bit phase
//                 undefined -> 4-entry full-step coil sequence, 2-bit phase
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   en          run request (level)
//   dir         direction, 1 = forward, 0 = reverse
//   limit       hard-stop request (level), overrides everything
//   signal      coil drive lines [3:0], 0000 while idle
//   step_pulse  one-cycle strobe in the cycle after a step was taken
//   position    signed step count, wraps two's-complement
//   busy        high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module stepper_ramp_sequencer #(
    parameter int MAX_PERIOD = 100000,
    parameter int MIN_PERIOD = 25000,
    parameter int RAMP_STEP  = 2500,
    parameter int POS_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    limit,
    output logic [3:0]              signal,
    output logic                    step_pulse,
    output logic signed [POS_W-1:0] position,
    output logic                    busy
);

    localparam int PW = $clog2(MAX_PERIOD + 1);
`ifdef HALF_STEP_EN
    localparam int PH_W = 3;
`else
    localparam int PH_W = 2;
`endif

    localparam logic [PW-1:0] MAX_P  = PW'(MAX_PERIOD);
    localparam logic [PW-1:0] MIN_P  = PW'(MIN_PERIOD);
    localparam logic [PW-1:0] RAMP_P = PW'(RAMP_STEP);

    typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           period_q, period_d;
    logic [PW-1:0]           cnt_q, cnt_d;
    logic [PH_W-1:0]         ph_q, ph_d;
    logic                    ldir_q, ldir_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic [3:0]              signal_q, signal_d;
    logic                    step_pulse_q, step_pulse_d;
    logic                    busy_q, busy_d;

    logic                    step_evt;
    logic                    stop_req;
    logic [31:0]             period_w;
    logic [PW-1:0]           period_dn;
    logic [PW-1:0]           period_up;

    function automatic logic [3:0] coil_pattern(input logic [PH_W-1:0] idx);
        logic [3:0] pat;
        pat = 4'b0000;
`ifdef HALF_STEP_EN
        case (idx)
            3'd0: pat = 4'b1000;
            3'd1: pat = 4'b1100;
            3'd2: pat = 4'b0100;
            3'd3: pat = 4'b0110;
            3'd4: pat = 4'b0010;
            3'd5: pat = 4'b0011;
            3'd6: pat = 4'b0001;
            3'd7: pat = 4'b1001;
        endcase
`else
        case (idx)
            2'd0: pat = 4'b1100;
            2'd1: pat = 4'b0110;
            2'd2: pat = 4'b0011;
            2'd3: pat = 4'b1001;
        endcase
`endif
        return pat;
    endfunction

    // Saturating ramp arithmetic is evaluated at 32 bits so that neither
    // period - RAMP_STEP nor period + RAMP_STEP can wrap in the PW-bit field.
    assign period_w  = 32'(period_q);
    assign period_dn = (period_w > 32'(MIN_PERIOD) + 32'(RAMP_STEP)) ? period_q - RAMP_P : MIN_P;
    assign period_up = (period_w + 32'(RAMP_STEP) < 32'(MAX_PERIOD)) ? period_q + RAMP_P : MAX_P;

    assign step_evt = (cnt_q == (period_q - PW'(1)));
    assign stop_req = !en || (dir != ldir_q);

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        cnt_d        = cnt_q;
        ph_d         = ph_q;
        ldir_d       = ldir_q;
        pos_d        = pos_q;
        step_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && !limit) begin
                    ldir_d   = dir;
                    period_d = MAX_P;
                    cnt_d    = '0;
                    state_d  = S_ACCEL;
                end
            end
            default: begin
                if (limit) begin
                    // Hard stop: no step on this edge, phase and position kept.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (step_evt) begin
                        cnt_d        = '0;
                        step_pulse_d = 1'b1;
                        ph_d         = ldir_q ? ph_q + PH_W'(1) : ph_q - PH_W'(1);
                        pos_d        = ldir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                        case (state_q)
                            S_ACCEL: begin
                                period_d = period_dn;
                                if (period_dn == MIN_P) begin
                                    state_d = S_CRUISE;
                                end
                            end
                            S_DECEL: begin
                                if (period_q == MAX_P) begin
                                    state_d = S_IDLE;
                                end else begin
                                    period_d = period_up;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt_d = cnt_q + PW'(1);
                    end
                    // A stop/reverse request overrides any ACCEL->CRUISE move
                    // made above; the period update of this edge still stands.
                    if ((state_q == S_ACCEL || state_q == S_CRUISE) && stop_req) begin
                        state_d = S_DECEL;
                    end
                end
            end
        endcase

        // Outputs are registered from next-state values so they line up with
        // the state they describe.
        signal_d = (state_d == S_IDLE) ? 4'b0000 : coil_pattern(ph_d);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            period_q     <= MAX_P;
            cnt_q        <= '0;
            ph_q         <= '0;
            ldir_q       <= 1'b0;
            pos_q        <= '0;
            signal_q     <= 4'b0000;
            step_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            ph_q         <= ph_d;
            ldir_q       <= ldir_d;
            pos_q        <= pos_d;
            signal_q     <= signal_d;
            step_pulse_q <= step_pulse_d;
            busy_q       <= busy_d;
        end
    end

    assign signal     = signal_q;
    assign step_pulse = step_pulse_q;
    assign position   = pos_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_stepper_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for stepper_ramp_sequencer (MAX=8, MIN=4, RAMP=2, POS_W=8).
// A countdown-based motion model predicts every output each cycle; directed
// scenarios add hand-computed step timings, phases and positions.
// ---------------------------------------------------------------------------
module tb_stepper_ramp_sequencer;

    localparam int MAXP = 8;
    localparam int MINP = 4;
    localparam int RAMP = 2;
    localparam int PW   = 8;
`ifdef HALF_STEP_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 4;
`endif

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic                 en    = 1'b0;
    logic                 dir   = 1'b1;
    logic                 limit = 1'b0;
    logic [3:0]           signal;
    logic                 step_pulse;
    logic signed [PW-1:0] position;
    logic                 busy;

    stepper_ramp_sequencer #(
        .MAX_PERIOD(MAXP),
        .MIN_PERIOD(MINP),
        .RAMP_STEP (RAMP),
        .POS_W     (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .limit     (limit),
        .signal    (signal),
        .step_pulse(step_pulse),
        .position  (position),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_ACCEL, M_CRUISE, M_DECEL} mmode_t;
    mmode_t     m_mode   = M_IDLE;
    int         m_period = MAXP;
    int         m_left   = 0;     // edges remaining until the next step
    int         m_ph     = 0;
    int         m_pos    = 0;
    bit         m_ldir   = 1'b0;
    bit         m_pulse  = 1'b0;
    logic [3:0] pat [NPH];

    initial begin
`ifdef HALF_STEP_EN
        pat = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
        pat = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif
    end

    task automatic model_edge();
        mmode_t nxt;
        bit     stop;
        m_pulse = 1'b0;
        if (m_mode == M_IDLE) begin
            if (en && !limit) begin
                m_mode   = M_ACCEL;
                m_ldir   = dir;
                m_period = MAXP;
                m_left   = MAXP;
            end
        end else if (limit) begin
            m_mode = M_IDLE;
        end else begin
            stop   = !en || (dir != m_ldir);
            nxt    = m_mode;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_pulse = 1'b1;
                m_ph    = m_ldir ? (m_ph + 1) % NPH : (m_ph + NPH - 1) % NPH;
                m_pos   = m_ldir ? m_pos + 1 : m_pos - 1;
                if (m_mode == M_ACCEL) begin
                    m_period = (m_period - RAMP < MINP) ? MINP : m_period - RAMP;
                    if (m_period == MINP) nxt = M_CRUISE;
                end else if (m_mode == M_DECEL) begin
                    if (m_period == MAXP) nxt = M_IDLE;
                    else m_period = (m_period + RAMP > MAXP) ? MAXP : m_period + RAMP;
                end
                m_left = m_period;
            end
            if (stop && (m_mode == M_ACCEL || m_mode == M_CRUISE)) nxt = M_DECEL;
            m_mode = nxt;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode   = M_IDLE;
            m_period = MAXP;
            m_left   = 0;
            m_ph     = 0;
            m_pos    = 0;
            m_pulse  = 1'b0;
        end else begin
            model_edge();
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_on = 1'b0;

    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            check("model_signal", 32'(signal), 32'((m_mode == M_IDLE) ? 4'b0000 : pat[m_ph]));
            check("model_busy", 32'(busy), 32'(m_mode != M_IDLE));
            check("model_pulse", 32'(step_pulse), 32'(m_pulse));
            check("model_position", 32'($unsigned(position)), 32'(m_pos[PW-1:0]));
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_pulse(input string name, input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!step_pulse && waited < budget);
        if (!step_pulse) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no step_pulse within %0d cycles", name, budget);
        end else begin
            $display("step %s: pos=%0d signal=%b after %0d cycles", name, position, signal, waited);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int w;
        int k;
        int cnt;
        int got_t [5];
        logic [3:0] got_s [5];
        int exp_t [5];
        logic [3:0] exp_s [5];
        logic [3:0] hs_exp [8];

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_signal", 32'(signal), 32'h0);
        check("reset_pulse", 32'(step_pulse), 32'h0);
        check("reset_position", 32'($unsigned(position)), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst    = 1'b0;
        cmp_on = 1'b1;
        repeat (2) @(negedge clk);

`ifdef HALF_STEP_EN
        hs_exp = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001, 4'b1000};
        en = 1'b1;
        dir = 1'b1;
        @(negedge clk);
        check("half_entry_signal", 32'(signal), 32'h8);
        for (int i = 0; i < 8; i++) begin
            wait_pulse("half", 20, w);
            check("half_signal", 32'(signal), 32'(hs_exp[i]));
        end
        check("half_position", 32'($unsigned(position)), 32'd8);
        en = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("half_stops", 32'(busy), 32'h0);
`else
        hs_exp = '{default: 4'b0000};
        // ramp up: en sampled at edge 0
        exp_t = '{9, 15, 19, 23, 27};
        exp_s = '{4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110};
        en  = 1'b1;
        dir = 1'b1;
        k   = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (t == 1) begin
                check("start_busy", 32'(busy), 32'h1);
                check("start_signal", 32'(signal), 32'hC);
            end
            if (step_pulse && k < 5) begin
                got_t[k] = t;
                got_s[k] = signal;
                $display("step ramp_up: t=%0d pos=%0d signal=%b", t, position, signal);
                k++;
            end
        end
        check("ramp_up_steps", 32'(k), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("ramp_up_time", 32'(got_t[i]), 32'(exp_t[i]));
            check("ramp_up_signal", 32'(got_s[i]), 32'(exp_s[i]));
        end
        check("ramp_up_position", 32'($unsigned(position)), 32'd5);

        // ramp down from cruise
        wait_pulse("cruise", 20, w);
        check("cruise_interval", 32'(w), 32'd1);
        en = 1'b0;
        wait_pulse("down1", 20, w);
        check("down_interval1", 32'(w), 32'd4);
        wait_pulse("down2", 20, w);
        check("down_interval2", 32'(w), 32'd6);
        wait_pulse("down3", 20, w);
        check("down_interval3", 32'(w), 32'd8);
        check("down_idle_busy", 32'(busy), 32'h0);
        check("down_idle_signal", 32'(signal), 32'h0);
        check("down_position", 32'($unsigned(position)), 32'd9);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (step_pulse || busy) cnt++;
        end
        check("down_stays_idle", 32'(cnt), 32'd0);

        // hard stop mid-ACCEL
        en = 1'b1;
        wait_pulse("accel", 20, w);
        check("first_step_latency", 32'(w), 32'd9);
        @(negedge clk);
        limit = 1'b1;
        @(negedge clk);
        check("limit_busy", 32'(busy), 32'h0);
        check("limit_signal", 32'(signal), 32'h0);
        check("limit_pulse", 32'(step_pulse), 32'h0);
        check("limit_position", 32'($unsigned(position)), 32'd10);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (step_pulse || busy) cnt++;
        end
        check("limit_holds", 32'(cnt), 32'd0);
        limit = 1'b0;
        @(negedge clk);
        check("restart_busy", 32'(busy), 32'h1);
        check("restart_signal", 32'(signal), 32'h3);

        // reverse from cruise
        wait_pulse("rev_a1", 20, w);
        check("rev_a1_interval", 32'(w), 32'd8);
        wait_pulse("rev_a2", 20, w);
        wait_pulse("rev_a3", 20, w);
        check("rev_a3_interval", 32'(w), 32'd4);
        check("rev_pre_position", 32'($unsigned(position)), 32'd13);
        dir = 1'b0;
        wait_pulse("rev_d1", 20, w);
        check("rev_d1_interval", 32'(w), 32'd4);
        wait_pulse("rev_d2", 20, w);
        check("rev_d2_interval", 32'(w), 32'd6);
        wait_pulse("rev_d3", 20, w);
        check("rev_d3_interval", 32'(w), 32'd8);
        check("rev_idle_busy", 32'(busy), 32'h0);
        check("rev_peak_position", 32'($unsigned(position)), 32'd16);
        @(negedge clk);
        check("rev_restart_busy", 32'(busy), 32'h1);
        check("rev_restart_signal", 32'(signal), 32'hC);
        wait_pulse("rev_r1", 20, w);
        check("rev_r1_interval", 32'(w), 32'd8);
        check("rev_r1_position", 32'($unsigned(position)), 32'd15);
        check("rev_r1_signal", 32'(signal), 32'h9);
        wait_pulse("rev_r2", 20, w);
        check("rev_r2_position", 32'($unsigned(position)), 32'd14);
        check("rev_r2_signal", 32'(signal), 32'h3);

        // wrap and asynchronous reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        dir = 1'b1;
        for (int i = 1; i <= 128; i++) begin
            wait_pulse("wrap", 20, w);
            if (i == 127) check("wrap_127", 32'($unsigned(position)), 32'h7F);
            if (i == 128) check("wrap_128", 32'($unsigned(position)), 32'h80);
        end
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_signal", 32'(signal), 32'h0);
        check("async_rst_pulse", 32'(step_pulse), 32'h0);
        check("async_rst_position", 32'($unsigned(position)), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
